// File: rtl/dccm_lsu.sv
// Load/store initiator for the closely-coupled data RAM. It checks range and alignment,
// drives the DCCM request port, and for loads returns the lane-selected, extended read data.
module dccm_lsu #(
    parameter int unsigned WD        = 1024,
    parameter int unsigned AM        = 11,
    parameter int unsigned AL        = 2,
    parameter logic [31:0] DCCM_BASE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_load,
    input  logic [1:0]        lsu_req_size,
    input  logic              lsu_req_unsigned,
    input  logic [31:0]       lsu_req_addr,
    input  logic [31:0]       lsu_req_wdata,
    input  logic [4:0]        lsu_req_rd,
    output logic              lsu_ld_valid,
    output logic [31:0]       lsu_ld_data,
    output logic [4:0]        lsu_ld_rd,
    output logic              lsu_st_done,
    output logic              lsu_fault,
    output logic [31:0]       lsu_fault_addr,
    output logic              lsu_fault_load,
    output logic              dccm_cen,
    output logic [AM-AL:0]    dccm_addr,
    output logic [3:0]        dccm_wenb,
    output logic [31:0]       dccm_din,
    input  logic [31:0]       dccm_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        LD_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DCCM_BYTES = 32'(4 * WD);

    state_t      state_q, state_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_uns_q, ld_uns_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        st_done_q, st_done_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        fault_load_q, fault_load_d;

    logic [31:0] offset_s;
    logic        aligned_s;
    logic        legal_s;
    logic        accept_s;

    // Byte lane select followed by sign or zero extension of the raw RAM word.
    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    load_extend = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    load_extend = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    // Request legality: range check is modulo 2^32 so addresses below the base fault.
    always_comb begin
        offset_s = lsu_req_addr - DCCM_BASE;
        case (lsu_req_size)
            2'd0:    aligned_s = 1'b1;
            2'd1:    aligned_s = (lsu_req_addr[0] == 1'b0);
            2'd2:    aligned_s = (lsu_req_addr[1:0] == 2'b00);
            default: aligned_s = 1'b0;
        endcase
        legal_s       = aligned_s && (offset_s < DCCM_BYTES);
        lsu_req_ready = (state_q == IDLE) && !rst;
        accept_s      = lsu_req_valid && lsu_req_ready;
    end

    // DCCM request port, driven in the accept cycle for legal requests only.
    always_comb begin
        dccm_cen  = 1'b0;
        dccm_wenb = 4'b0000;
        dccm_addr = offset_s[AM:AL];
        case (lsu_req_size)
            2'd0:    dccm_din = {4{lsu_req_wdata[7:0]}};
            2'd1:    dccm_din = {2{lsu_req_wdata[15:0]}};
            default: dccm_din = lsu_req_wdata;
        endcase
        if (accept_s && legal_s) begin
            dccm_cen = 1'b1;
            if (!lsu_req_load) begin
                case (lsu_req_size)
                    2'd0:    dccm_wenb = 4'b0001 << lsu_req_addr[1:0];
                    2'd1:    dccm_wenb = 4'b0011 << lsu_req_addr[1:0];
                    2'd2:    dccm_wenb = 4'b1111;
                    default: dccm_wenb = 4'b0000;
                endcase
            end else begin
                dccm_wenb = 4'b0000;
            end
        end else begin
            dccm_cen  = 1'b0;
        end
    end

    // Next-state logic for the load FSM and the response registers.
    always_comb begin
        state_d      = state_q;
        ld_off_d     = ld_off_q;
        ld_size_d    = ld_size_q;
        ld_uns_d     = ld_uns_q;
        ld_rd_d      = ld_rd_q;
        ld_data_d    = ld_data_q;
        st_done_d    = 1'b0;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;
        fault_load_d = fault_load_q;
        case (state_q)
            IDLE: begin
                if (accept_s && !legal_s) begin
                    fault_d      = 1'b1;
                    fault_addr_d = lsu_req_addr;
                    fault_load_d = lsu_req_load;
                end else if (accept_s && lsu_req_load) begin
                    state_d   = LD_WAIT;
                    ld_off_d  = lsu_req_addr[1:0];
                    ld_size_d = lsu_req_size;
                    ld_uns_d  = lsu_req_unsigned;
                    ld_rd_d   = lsu_req_rd;
                end else if (accept_s) begin
                    st_done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LD_WAIT: begin
                ld_data_d = load_extend(dccm_dout, ld_off_q, ld_size_q, ld_uns_q);
                state_d   = LD_RESP;
            end
            LD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ld_off_q     <= 2'b00;
            ld_size_q    <= 2'b00;
            ld_uns_q     <= 1'b0;
            ld_rd_q      <= 5'd0;
            ld_data_q    <= 32'h0000_0000;
            st_done_q    <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0000_0000;
            fault_load_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_off_q     <= ld_off_d;
            ld_size_q    <= ld_size_d;
            ld_uns_q     <= ld_uns_d;
            ld_rd_q      <= ld_rd_d;
            ld_data_q    <= ld_data_d;
            st_done_q    <= st_done_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            fault_load_q <= fault_load_d;
        end
    end

    assign lsu_ld_valid   = (state_q == LD_RESP);
    assign lsu_ld_data    = ld_data_q;
    assign lsu_ld_rd      = ld_rd_q;
    assign lsu_st_done    = st_done_q;
    assign lsu_fault      = fault_q;
    assign lsu_fault_addr = fault_addr_q;
    assign lsu_fault_load = fault_load_q;

endmodule

// File: tb/tb_dccm_lsu.sv
// Directed bench for dccm_lsu with a behavioural 1-cycle-latency DCCM attached.
module tb_dccm_lsu;

    logic        clk;
    logic        rst;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_load;
    logic [1:0]  lsu_req_size;
    logic        lsu_req_unsigned;
    logic [31:0] lsu_req_addr;
    logic [31:0] lsu_req_wdata;
    logic [4:0]  lsu_req_rd;
    logic        lsu_ld_valid;
    logic [31:0] lsu_ld_data;
    logic [4:0]  lsu_ld_rd;
    logic        lsu_st_done;
    logic        lsu_fault;
    logic [31:0] lsu_fault_addr;
    logic        lsu_fault_load;
    logic        dccm_cen;
    logic [9:0]  dccm_addr;
    logic [3:0]  dccm_wenb;
    logic [31:0] dccm_din;
    logic [31:0] dccm_dout;

    int checks = 0;
    int errors = 0;

    bit [31:0] mem [0:1023];

    dccm_lsu dut (
        .clk(clk), .rst(rst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_load(lsu_req_load), .lsu_req_size(lsu_req_size),
        .lsu_req_unsigned(lsu_req_unsigned), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_rd(lsu_req_rd),
        .lsu_ld_valid(lsu_ld_valid), .lsu_ld_data(lsu_ld_data), .lsu_ld_rd(lsu_ld_rd),
        .lsu_st_done(lsu_st_done), .lsu_fault(lsu_fault),
        .lsu_fault_addr(lsu_fault_addr), .lsu_fault_load(lsu_fault_load),
        .dccm_cen(dccm_cen), .dccm_addr(dccm_addr), .dccm_wenb(dccm_wenb),
        .dccm_din(dccm_din), .dccm_dout(dccm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DCCM: byte-masked write, read data registered one cycle later.
    always @(posedge clk) begin
        if (dccm_cen) begin
            for (int b = 0; b < 4; b++) begin
                if (dccm_wenb[b]) mem[dccm_addr][8*b +: 8] <= dccm_din[8*b +: 8];
            end
            dccm_dout <= mem[dccm_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic ld, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        lsu_req_valid    = 1'b1;
        lsu_req_load     = ld;
        lsu_req_size     = sz;
        lsu_req_unsigned = uns;
        lsu_req_addr     = a;
        lsu_req_wdata    = wd;
        lsu_req_rd       = rd;
        #1;
    endtask

    // Called at a negedge; returns at the negedge of N+1 with valid low.
    task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] exp_wenb,
                            input logic [31:0] exp_din);
        set_req(1'b0, sz, 1'b0, a, wd, 5'd0);
        chk({tag, "_cen"}, {31'd0, dccm_cen}, 32'd1);
        chk({tag, "_wenb"}, {28'd0, dccm_wenb}, {28'd0, exp_wenb});
        chk({tag, "_din"}, dccm_din, exp_din);
        chk({tag, "_addr"}, {22'd0, dccm_addr}, {22'd0, a[11:2]});
        @(negedge clk);
        lsu_req_valid = 1'b0;
        chk({tag, "_st_done"}, {31'd0, lsu_st_done}, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge of N+3 with valid low.
    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [4:0] rd, input logic [31:0] exp);
        set_req(1'b1, sz, uns, a, 32'd0, rd);
        chk({tag, "_cen"}, {31'd0, dccm_cen}, 32'd1);
        chk({tag, "_wenb"}, {28'd0, dccm_wenb}, 32'd0);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        chk({tag, "_early_valid"}, {31'd0, lsu_ld_valid}, 32'd0);
        chk({tag, "_ready_wait"}, {31'd0, lsu_req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_ld_valid"}, {31'd0, lsu_ld_valid}, 32'd1);
        chk({tag, "_ld_data"}, lsu_ld_data, exp);
        chk({tag, "_ld_rd"}, {27'd0, lsu_ld_rd}, {27'd0, rd});
        chk({tag, "_ready_resp"}, {31'd0, lsu_req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, {31'd0, lsu_ld_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, lsu_req_ready}, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge of N+2.
    task automatic do_fault(input string tag, input logic ld, input logic [1:0] sz,
                            input logic [31:0] a);
        set_req(ld, sz, 1'b0, a, 32'h5555_5555, 5'd3);
        chk({tag, "_cen"}, {31'd0, dccm_cen}, 32'd0);
        chk({tag, "_wenb"}, {28'd0, dccm_wenb}, 32'd0);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        chk({tag, "_fault"}, {31'd0, lsu_fault}, 32'd1);
        chk({tag, "_fault_addr"}, lsu_fault_addr, a);
        chk({tag, "_fault_load"}, {31'd0, lsu_fault_load}, {31'd0, ld});
        chk({tag, "_no_st_done"}, {31'd0, lsu_st_done}, 32'd0);
        chk({tag, "_ready"}, {31'd0, lsu_req_ready}, 32'd1);
        @(negedge clk);
        chk({tag, "_fault_pulse"}, {31'd0, lsu_fault}, 32'd0);
        chk({tag, "_no_ld_valid"}, {31'd0, lsu_ld_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        lsu_req_valid = 1'b0; lsu_req_load = 1'b0; lsu_req_size = 2'd0;
        lsu_req_unsigned = 1'b0; lsu_req_addr = 32'd0; lsu_req_wdata = 32'd0;
        lsu_req_rd = 5'd0;
        repeat (2) @(negedge clk);
        set_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h1111_1111, 5'd1);
        chk("rst_cen", {31'd0, dccm_cen}, 32'd0);
        chk("rst_wenb", {28'd0, dccm_wenb}, 32'd0);
        chk("rst_ready", {31'd0, lsu_req_ready}, 32'd0);
        chk("rst_ld_valid", {31'd0, lsu_ld_valid}, 32'd0);
        chk("rst_st_done", {31'd0, lsu_st_done}, 32'd0);
        chk("rst_fault", {31'd0, lsu_fault}, 32'd0);
        chk("rst_ld_data", lsu_ld_data, 32'd0);
        chk("rst_ld_rd", {27'd0, lsu_ld_rd}, 32'd0);
        chk("rst_fault_addr", lsu_fault_addr, 32'd0);
        chk("rst_fault_load", {31'd0, lsu_fault_load}, 32'd0);
        lsu_req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Word store then load
        do_store("sw100", 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_load("lw100", 2'd2, 1'b0, 32'h0000_0100, 5'd5, 32'hDEAD_BEEF);

        // Sub-word loads with extension
        do_store("sw200", 2'd2, 32'h0000_0200, 32'h80FF_7F01, 4'b1111, 32'h80FF_7F01);
        do_load("lb203", 2'd0, 1'b0, 32'h0000_0203, 5'd6, 32'hFFFF_FF80);
        do_load("lbu203", 2'd0, 1'b1, 32'h0000_0203, 5'd7, 32'h0000_0080);
        do_load("lh202", 2'd1, 1'b0, 32'h0000_0202, 5'd8, 32'hFFFF_80FF);
        do_load("lhu200", 2'd1, 1'b1, 32'h0000_0200, 5'd9, 32'h0000_7F01);

        // Sub-word stores
        do_store("sb301", 2'd0, 32'h0000_0301, 32'h0000_00AA, 4'b0010, 32'hAAAA_AAAA);
        do_store("sh302", 2'd1, 32'h0000_0302, 32'h0000_1234, 4'b1100, 32'h1234_1234);
        do_load("lw300", 2'd2, 1'b0, 32'h0000_0300, 5'd10, 32'h1234_AA00);

        // Illegal accesses
        do_fault("lh101", 1'b1, 2'd1, 32'h0000_0101);
        do_fault("lw102", 1'b1, 2'd2, 32'h0000_0102);
        do_fault("sz3", 1'b1, 2'd3, 32'h0000_0000);
        do_fault("lw1000", 1'b1, 2'd2, 32'h0000_1000);
        do_fault("swmis", 1'b0, 2'd2, 32'h0000_0002);
        do_fault("lwwrap", 1'b1, 2'd2, 32'hFFFF_FFFC);
        chk("fault_data_hold", lsu_ld_data, 32'h1234_AA00);

        // Back-to-back stores, one per cycle
        for (int i = 0; i < 8; i++) begin
            set_req(1'b0, 2'd2, 1'b0, 32'h0000_0400 + 32'(4 * i), 32'h0000_1000 + 32'(i), 5'd0);
            chk("b2b_cen", {31'd0, dccm_cen}, 32'd1);
            chk("b2b_addr", {22'd0, dccm_addr}, 32'h0000_0100 + 32'(i));
            @(negedge clk);
            chk("b2b_st_done", {31'd0, lsu_st_done}, 32'd1);
        end

        // Load with valid held through the busy window
        set_req(1'b1, 2'd2, 1'b0, 32'h0000_0404, 32'd0, 5'd11);
        chk("hold_cen0", {31'd0, dccm_cen}, 32'd1);
        @(negedge clk);
        set_req(1'b1, 2'd2, 1'b0, 32'h0000_0410, 32'd0, 5'd12);
        chk("hold_ready1", {31'd0, lsu_req_ready}, 32'd0);
        chk("hold_cen1", {31'd0, dccm_cen}, 32'd0);
        chk("hold_last_st_done", {31'd0, lsu_st_done}, 32'd0);
        @(negedge clk);
        chk("hold_ld_valid", {31'd0, lsu_ld_valid}, 32'd1);
        chk("hold_ld_data", lsu_ld_data, 32'h0000_1001);
        chk("hold_ld_rd", {27'd0, lsu_ld_rd}, 32'd11);
        chk("hold_ready2", {31'd0, lsu_req_ready}, 32'd0);
        chk("hold_cen2", {31'd0, dccm_cen}, 32'd0);
        @(negedge clk);
        chk("hold_ready3", {31'd0, lsu_req_ready}, 32'd1);
        chk("hold_cen3", {31'd0, dccm_cen}, 32'd1);
        chk("hold_addr3", {22'd0, dccm_addr}, 32'h0000_0104);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("hold2_ld_valid", {31'd0, lsu_ld_valid}, 32'd1);
        chk("hold2_ld_data", lsu_ld_data, 32'h0000_1004);
        chk("hold2_ld_rd", {27'd0, lsu_ld_rd}, 32'd12);
        @(negedge clk);

        // Reset while the load waits for read data
        set_req(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 5'd13);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ld_valid", {31'd0, lsu_ld_valid}, 32'd0);
        chk("abort_ready", {31'd0, lsu_req_ready}, 32'd0);
        chk("abort_st_done", {31'd0, lsu_st_done}, 32'd0);
        chk("abort_fault", {31'd0, lsu_fault}, 32'd0);
        chk("abort_ld_data", lsu_ld_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ld_valid2", {31'd0, lsu_ld_valid}, 32'd0);
        chk("abort_ready2", {31'd0, lsu_req_ready}, 32'd1);
        do_load("lw_after_rst", 2'd2, 1'b0, 32'h0000_0100, 5'd14, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
